// File: rtl/sample_bus_arbiter.sv
// Round-robin owner arbiter for the shared `e` bus: one grant at a time, hold limit,
// and a driver-free turnaround gap between owners.
module sample_bus_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      owner,
    output logic            oe,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state;
    logic [7:0]      hold_cnt;
    logic [3:0]      turn_cnt;
    logic [1:0]      last;
    logic [1:0]      pick;
    logic [NREQ-1:0] pick_oh;
    logic            pick_vld;
    logic            rel_norm;

    // First requester after the last-served agent, wrapping modulo NREQ.
    always_comb begin
        int idx;
        pick     = '0;
        pick_oh  = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!pick_vld && |(req & (ONE << idx))) begin
                pick_vld = 1'b1;
                pick     = 2'(idx);
                pick_oh  = ONE << idx;
            end
        end
    end

    // gnt holds the owner's one-hot, so masking with it ignores non-owner bits.
    assign rel_norm = |(done & gnt) || !(|(req & gnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last     <= 2'(NREQ - 1);
            oe       <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt      <= pick_oh;
                        owner    <= pick;
                        last     <= pick;
                        oe       <= 1'b1;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd1;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (rel_norm || hold_cnt == 8'(MAX_HOLD)) begin
                        gnt      <= '0;
                        oe       <= 1'b0;
                        turn_cnt <= 4'(TURN_CYC);
                        timeout  <= !rel_norm;
                        state    <= TURN;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    turn_cnt <= turn_cnt - 4'd1;
                    if (turn_cnt <= 4'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_bus_arbiter.sv
// Directed bench for sample_bus_arbiter: vector table plus hand sequences for
// timeout, limit/done coincidence, async reset and round-robin order.
module tb_sample_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       oe;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    sample_bus_arbiter #(.NREQ(3), .MAX_HOLD(8), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
        .owner(owner), .oe(oe), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] done;
        logic [2:0] gnt;
        logic [1:0] owner;
        logic       oe;
        logic       busy;
        logic       tmo;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and check oe tracks gnt.
    task automatic step();
        @(posedge clk);
        #1;
        check("oe_eq_gnt", {31'd0, oe}, {31'd0, gnt != 3'b000});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] one;
        int         gap;
        int         order[4];

        one = 3'b001;
        order = '{0, 1, 2, 0};

        //            req     done    gnt     own   oe    busy  tmo
        tbl[0]  = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{3'b001, 3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{3'b111, 3'b100, 3'b010, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{3'b101, 3'b100, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3'b111, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{3'b111, 3'b100, 3'b000, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{3'b111, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{3'b111, 3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        #12;
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd0);
        check("rst_flags", {29'd0, oe, busy, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("tbl%0d_gnt", i), {29'd0, gnt}, {29'd0, tbl[i].gnt});
            check($sformatf("tbl%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].owner});
            check($sformatf("tbl%0d_flags", i), {29'd0, oe, busy, timeout},
                  {29'd0, tbl[i].oe, tbl[i].busy, tbl[i].tmo});
        end

        // Hold limit: 8 cycles of grant, one timeout pulse, then re-grant.
        do_reset();
        req = 3'b001;
        step();
        check("to_grant", {29'd0, gnt}, 32'd1);
        for (int i = 2; i <= 8; i++) begin
            step();
            check($sformatf("to_hold%0d", i), {28'd0, gnt, timeout}, {28'd0, 3'b001, 1'b0});
        end
        step();
        check("to_release", {28'd0, gnt, timeout}, {28'd0, 3'b000, 1'b1});
        step();
        check("to_single_pulse", {27'd0, gnt, busy, timeout}, 32'd0);
        step();
        check("to_regrant", {29'd0, gnt}, 32'd1);

        // done lands on the same edge as the limit: plain release, no pulse.
        for (int i = 2; i <= 8; i++) step();
        check("lim_still_owned", {29'd0, gnt}, 32'd1);
        done = 3'b001;
        step();
        check("lim_done_release", {28'd0, gnt, timeout}, 32'd0);
        done = 3'b000;
        req  = 3'b000;
        step();
        check("lim_no_late_pulse", {31'd0, timeout}, 32'd0);

        // Timeout fairness: agent 0 times out, agent 1 is served before it again.
        do_reset();
        req = 3'b001;
        for (int i = 1; i <= 8; i++) step();
        req = 3'b011;
        step();
        check("fair_timeout", {31'd0, timeout}, 32'd1);
        step();
        step();
        check("fair_next_is_1", {29'd0, gnt}, 32'd2);

        // Async reset during ownership, then pointer back to agent 0 first.
        do_reset();
        req = 3'b010;
        step();
        check("ar_owned", {29'd0, gnt}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async_drop", {28'd0, gnt, oe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 3'b110;
        step();
        check("ar_ptr_reset", {29'd0, gnt}, 32'd2);

        // Round-robin 0,1,2,0 with done after two cycles, gap of two idle-bus cycles.
        do_reset();
        req = 3'b111;
        gap = 0;
        for (int k = 0; k < 4; k++) begin
            while (gnt == 3'b000 && gap < 10) begin
                step();
                if (gnt == 3'b000) gap++;
            end
            check($sformatf("rr%0d_gnt", k), {29'd0, gnt}, {29'd0, one << order[k]});
            if (k > 0) check($sformatf("rr%0d_gap", k), gap, 32'd2);
            step();
            check($sformatf("rr%0d_hold", k), {29'd0, gnt}, {29'd0, one << order[k]});
            done = gnt;
            step();
            check($sformatf("rr%0d_rel", k), {29'd0, gnt}, 32'd0);
            done = 3'b000;
            gap  = 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
